// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx packet arbiter: state encoding, port
// limit and a one-hot to index helper.
package uart_pkg;

  localparam int UART_ARB_MAX_PORTS = 8;

  typedef enum logic [1:0] {
    UART_ARB_IDLE,
    UART_ARB_XFER,
    UART_ARB_DRAIN,
    UART_ARB_GAP
  } uart_arb_state_e;

  // OR-reduction encoder; only valid for one-hot or all-zero inputs.
  function automatic logic [2:0] uart_oh2idx(input logic [UART_ARB_MAX_PORTS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < UART_ARB_MAX_PORTS; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first requester scanning upward from
// last+1 (mod PORTS). Output is all-zero when nothing requests.
module uart_rr_pick #(
  parameter int PORTS = 4,
  parameter int IDXW  = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDXW-1:0]  last,
  output logic [PORTS-1:0] onehot
);

  logic            found;
  logic [IDXW-1:0] idx;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = IDXW'((int'(last) + k) % PORTS);
      if (!found && req[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding one uart_tx serializer from PORTS
// AXI4-Stream byte sources, with drain wait and programmable idle gap.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  input  logic [PORTS-1:0]            s_axis_tlast,
  output logic [PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  input  logic                        tx_busy,
  input  logic [15:0]                 gap_cycles,
  output logic [PORTS-1:0]            grant,
  output logic                        active
);

  localparam int          IDXW       = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [15:0] BURST_LAST = 16'(MAX_BURST - 1);

  uart_arb_state_e        state_q, state_d;
  logic [PORTS-1:0]       grant_q, grant_d;
  logic [IDXW-1:0]        last_q, last_d;
  logic [15:0]            burst_q, burst_d;
  logic [15:0]            gap_q, gap_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;

  logic [PORTS-1:0][DATA_WIDTH-1:0] din;
  logic [PORTS-1:0]       pick_oh;
  logic [PORTS-1:0]       in_rdy;
  logic [IDXW-1:0]        g_idx;
  logic                   out_rdy, accept, g_last;

  assign din = s_axis_tdata;

  uart_rr_pick #(
    .PORTS (PORTS),
    .IDXW  (IDXW)
  ) u_pick (
    .req    (s_axis_tvalid),
    .last   (last_q),
    .onehot (pick_oh)
  );

  assign g_idx   = IDXW'(uart_oh2idx(UART_ARB_MAX_PORTS'(grant_q)));
  assign g_last  = s_axis_tlast[g_idx];
  // Output slot is free when empty or emptying this cycle: full throughput.
  assign out_rdy = !tvalid_q || m_axis_tready;
  assign in_rdy  = (state_q == UART_ARB_XFER) ? (grant_q & {PORTS{out_rdy}}) : '0;
  assign accept  = |(s_axis_tvalid & in_rdy);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    burst_d  = burst_q;
    gap_d    = gap_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;

    if (accept) begin
      tdata_d  = din[g_idx];
      tvalid_d = 1'b1;
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    unique case (state_q)
      UART_ARB_IDLE: begin
        if (|s_axis_tvalid) begin
          grant_d = pick_oh;
          burst_d = '0;
          state_d = UART_ARB_XFER;
        end
      end
      UART_ARB_XFER: begin
        if (accept) begin
          burst_d = burst_q + 16'd1;
          if (g_last || burst_q == BURST_LAST) begin
            last_d  = g_idx;
            state_d = UART_ARB_DRAIN;
          end
        end
      end
      UART_ARB_DRAIN: begin
        // Grant is held until the serializer has fully emptied.
        if (!tvalid_q && !tx_busy) begin
          gap_d   = gap_cycles;
          grant_d = '0;
          state_d = (gap_cycles != 16'd0) ? UART_ARB_GAP : UART_ARB_IDLE;
        end
      end
      UART_ARB_GAP: begin
        gap_d = gap_q - 16'd1;
        if (gap_q == 16'd1) state_d = UART_ARB_IDLE;
      end
      default: state_d = UART_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= UART_ARB_IDLE;
      grant_q  <= '0;
      last_q   <= IDXW'(PORTS - 1);
      burst_q  <= '0;
      gap_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      gap_q    <= gap_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign s_axis_tready = in_rdy;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign grant         = grant_q;
  assign active        = (state_q != UART_ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: random sources, sink backpressure and
// serializer busy model, checked against a packet-level arbitration model.
module tb_uart_tx_arb;

  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int MAXC  = 6000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [PORTS*DW-1:0]   s_tdata;
  logic [PORTS-1:0]      s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]         m_tdata;
  logic                  m_tvalid, m_tready, tx_busy;
  logic [15:0]           gap;
  logic [PORTS-1:0]      grant;
  logic                  active;

  always #5 clk = ~clk;

  uart_tx_arb #(.PORTS(PORTS), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .tx_busy       (tx_busy),
    .gap_cycles    (gap),
    .grant         (grant),
    .active        (active)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] send_q [PORTS][$];
  logic [8:0] exp_q  [PORTS][$];

  bit stall_en  = 1'b0;
  bit busy_hold = 1'b0;
  int busy_min  = 0;
  int busy_max  = 0;
  int rdy_mode  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input int p, input logic [7:0] d, input bit l);
    send_q[p].push_back({l, d});
    exp_q[p].push_back({l, d});
  endtask

  task automatic push_rand_pkt(input int p, input int len);
    for (int b = 0; b < len; b++) push_byte(p, 8'($urandom), b == len - 1);
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < PORTS; i++) n += send_q[i].size() + exp_q[i].size();
    return n;
  endfunction

  function automatic int rr_winner(input logic [PORTS-1:0] req, input int last);
    for (int k = 1; k <= PORTS; k++)
      if (req[(last + k) % PORTS]) return (last + k) % PORTS;
    return -1;
  endfunction

  // Source drivers: hold a presented byte until accepted.
  logic [PORTS-1:0] drv_hs;
  initial begin
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    forever begin
      @(negedge clk);
      drv_hs = s_tvalid & s_tready;
      @(posedge clk); #1;
      for (int i = 0; i < PORTS; i++) begin
        if (drv_hs[i] && send_q[i].size() > 0) void'(send_q[i].pop_front());
        if (send_q[i].size() == 0) begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
          s_tdata[i*DW +: DW] = '0;
        end else begin
          if (!(s_tvalid[i] && !drv_hs[i]))
            s_tvalid[i] = stall_en ? ($urandom_range(3, 0) != 0) : 1'b1;
          s_tdata[i*DW +: DW] = send_q[i][0][7:0];
          s_tlast[i]          = send_q[i][0][8];
        end
      end
    end
  end

  // Sink side: ready pattern and serializer busy after each byte.
  bit ohs_b;
  int btimer = 0;
  initial begin
    m_tready = 1'b1; tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      ohs_b = m_tvalid && m_tready;
      @(posedge clk); #1;
      if (!rst_n) btimer = 0;
      else if (ohs_b) btimer = (busy_max > 0) ? $urandom_range(busy_max, busy_min) : 0;
      else if (btimer > 0) btimer--;
      tx_busy = busy_hold || (btimer != 0);
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Monitor / reference model at packet level.
  int               mon_last = PORTS - 1;
  int               owner = -1;
  int               cnt = 0;
  bit               done = 1'b1;
  logic [PORTS-1:0] prev_grant = '0, prev_req = '0;
  bit               prev_busy = 0, prev_mvalid = 0;
  bit               pend_hs = 0;
  logic [7:0]       pend_byte = '0;
  bit               in_gap = 0;
  int               run = 0, gap_exp = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_last = PORTS - 1; owner = -1; cnt = 0; done = 1'b1;
        prev_grant = '0; prev_req = '0; prev_busy = 0; prev_mvalid = 0;
        pend_hs = 0; in_gap = 0; run = 0;
        continue;
      end
      if (pend_hs) begin
        chk("accept_to_mvalid", m_tvalid, 1);
        chk("accept_data", m_tdata, pend_byte);
      end
      chk("tready_only_owner", s_tready & ~grant, 0);
      if (grant != 0) chk("active_while_granted", active, 1);
      if (prev_grant == 0 && grant != 0) begin
        int w;
        w = rr_winner(prev_req, mon_last);
        chk("grant_winner", grant, (w < 0) ? 0 : (1 << w));
        owner = w; cnt = 0; done = 1'b0;
      end
      if (prev_grant != 0 && grant == 0) begin
        chk("burst_complete_at_release", done, 1);
        chk("drain_waits_busy", prev_busy, 0);
        chk("drain_waits_mvalid", prev_mvalid, 0);
        in_gap = 1; run = 0; gap_exp = int'(gap);
      end
      if (in_gap) begin
        if (active && grant == 0) run++;
        else begin
          chk("gap_length", run, gap_exp);
          in_gap = 0;
        end
      end
      if (m_tvalid && m_tready) begin
        bit ok;
        ok = (owner >= 0) && !done && (exp_q[owner].size() > 0);
        chk("output_expected", ok, 1);
        if (ok) begin
          logic [8:0] e;
          e = exp_q[owner].pop_front();
          chk("out_data", m_tdata, e[7:0]);
          cnt++;
          if (e[8] || cnt == MB) begin
            done = 1'b1;
            mon_last = owner;
          end
        end
      end
      pend_hs = |(s_tvalid & s_tready);
      for (int i = 0; i < PORTS; i++)
        if (s_tvalid[i] && s_tready[i]) pend_byte = s_tdata[i*DW +: DW];
      prev_grant  = grant;
      prev_req    = s_tvalid;
      prev_busy   = tx_busy;
      prev_mvalid = m_tvalid;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tready"}, s_tready, 0);
    chk({tag, "_mvalid"}, m_tvalid, 0);
    chk({tag, "_mdata"},  m_tdata, 0);
    chk({tag, "_grant"},  grant, 0);
    chk({tag, "_active"}, active, 0);
  endtask

  task automatic wait_idle();
    int n = 0, quiet = 0;
    while (quiet < 4 && n < MAXC) begin
      @(negedge clk);
      n++;
      if (pending() == 0 && !active && !m_tvalid) quiet++;
      else quiet = 0;
    end
    chk("idle_reached", n < MAXC, 1);
    chk("all_bytes_delivered", pending(), 0);
  endtask

  task automatic wait_grant(output bit ok);
    int n = 0;
    while (grant == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (grant != 0);
    chk("grant_seen", ok, 1);
  endtask

  initial begin
    bit ok;
    logic [PORTS-1:0] first_g;
    rst_n = 1'b0;
    gap   = 16'd4;
    repeat (3) @(posedge clk);
    #2 chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Single packet from port 2, gap 4.
    push_byte(2, 8'h11, 1'b0);
    push_byte(2, 8'h22, 1'b0);
    push_byte(2, 8'h33, 1'b1);
    wait_grant(ok);
    chk("single_pkt_grant", grant, 4'b0100);
    wait_idle();

    // Every port with a stream of 1-byte packets, no gap.
    gap = 16'd0;
    for (int r = 0; r < 6; r++)
      for (int p = 0; p < PORTS; p++) push_rand_pkt(p, 1);
    wait_idle();

    // Burst truncation at MB while another port competes.
    gap = 16'd2;
    push_rand_pkt(1, 10);
    push_rand_pkt(3, 6);
    wait_idle();

    // Toggling sink ready and long serializer busy.
    rdy_mode = 1; busy_min = 20; busy_max = 20;
    push_rand_pkt(0, 5);
    push_rand_pkt(2, 3);
    wait_idle();

    // Random traffic rounds.
    rdy_mode = 2; busy_min = 0; busy_max = 6; stall_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      gap = 16'($urandom_range(5, 0));
      for (int k = 0; k < 8; k++) push_rand_pkt($urandom_range(PORTS - 1, 0), $urandom_range(9, 1));
      wait_idle();
    end

    // gap 0: next grant one clock after the serializer drains.
    rdy_mode = 0; busy_min = 0; busy_max = 0; stall_en = 1'b0;
    gap = 16'd0; busy_hold = 1'b1;
    push_rand_pkt(0, 1);
    push_rand_pkt(1, 1);
    wait_grant(ok);
    first_g = grant;
    repeat (12) @(negedge clk);
    chk("drain_hold_grant", grant, first_g);
    @(posedge clk); #2 busy_hold = 1'b0;
    begin
      int n = 0;
      while ((tx_busy || m_tvalid) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("busy_released", n < 50, 1);
    end
    @(negedge clk);
    chk("gap0_idle_grant", grant, 0);
    chk("gap0_idle_active", active, 0);
    @(negedge clk);
    chk("gap0_next_grant", grant, first_g ^ 4'b0011);
    wait_idle();

    // Asynchronous reset in the middle of a packet.
    push_rand_pkt(0, 10);
    begin
      int n = 0;
      while (exp_q[0].size() > 7 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("midpkt_progress", n < 300, 1);
    end
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    for (int i = 0; i < PORTS; i++) begin
      send_q[i].delete();
      exp_q[i].delete();
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    push_rand_pkt(0, 1);
    push_rand_pkt(1, 1);
    wait_grant(ok);
    chk("post_reset_port0_wins", grant, 4'b0001);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin packet arbiter that shares one `uart_tx` serializer between `PORTS` AXI4-Stream byte sources. A grant is held for a whole packet (until `tlast`) or until `MAX_BURST` bytes, whichever comes first. After each packet the block waits for the serializer to drain and then inserts a programmable idle gap before re-arbitrating. It sits directly upstream of `uart_tx`; `m_axis_*` connects to its `s_axis_*`, and `tx_busy` connects to its `busy`.

## Interface
- `PORTS`, 4: number of requesters, range 2..8.
- `DATA_WIDTH`, 8: byte width, matches `uart_tx`.
- `MAX_BURST`, 64: maximum bytes per grant, range 1..65535.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata`  in  PORTS*DATA_WIDTH  packed inputs; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tvalid`  in  PORTS  per-port valid.
- `s_axis_tlast`  in  PORTS  per-port end of packet.
- `s_axis_tready`  out  PORTS  per-port ready.
- `m_axis_tdata`  out  DATA_WIDTH  byte to `uart_tx`.
- `m_axis_tvalid`  out  1  registered valid.
- `m_axis_tready`  in  1  from `uart_tx`.
- `tx_busy`  in  1  `uart_tx` busy.
- `gap_cycles`  in  16  idle clocks inserted after each packet; sampled on DRAIN→GAP.
- `grant`  out  PORTS  one-hot current owner; 0 when no port is granted.
- `active`  out  1  high in XFER, DRAIN or GAP.

## Operation
- States: IDLE, XFER, DRAIN, GAP.
- **IDLE**
  - If any `s_axis_tvalid` is set, pick the first requesting port scanning upward from `last+1` mod PORTS.
  - Load `grant`, clear `burst_cnt`, go to XFER.
  - Arbitration costs 1 clock. No data moves in IDLE.
- **XFER**
  - `s_axis_tready[g] = (!m_axis_tvalid || m_axis_tready)`. All other ports get ready=0.
  - On accept (valid && ready for port g): register the byte into `m_axis_tdata`, set `m_axis_tvalid`, increment `burst_cnt`.
  - `m_axis_tvalid` clears on an output handshake that has no simultaneous accept.
  - An accept and an output handshake in the same cycle keep valid at 1. This gives full throughput.
  - Exit to DRAIN on the accept where `tlast`=1, or where `burst_cnt` reaches MAX_BURST-1 (the MAX_BURST-th byte). Record `last = g`.
- **DRAIN**
  - `s_axis_tready` = 0.
  - Wait until `m_axis_tvalid` = 0 and `tx_busy` = 0.
  - Then load the gap counter with `gap_cycles`. Go to GAP if it is nonzero, otherwise go to IDLE.
- **GAP**
  - Decrement the counter each clock. Go to IDLE when it reaches 1.
  - `grant` drops to 0 on leaving DRAIN.
- A burst truncated by MAX_BURST does not change the next winner: rotation still advances past g. The source's remaining bytes form a new request.
- A requester that drops `tvalid` mid-packet keeps the grant. There is no timeout; the block waits.

## Timing
- Reset values: `s_axis_tready` = 0, `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `grant` = 0, `active` = 0, `last` = PORTS-1 (port 0 wins first), state IDLE.
- Reset mid-packet aborts immediately with no output cleanup. The in-flight byte is lost and `uart_tx` must be reset alongside.
- Latency:
  - Request in IDLE to first `s_axis_tready`: 1 clock.
  - Accept to `m_axis_tvalid`: 1 clock.
- Inter-packet dead time, measured after `tx_busy` falls: `gap_cycles` + 1 (IDLE) clocks minimum.
- Simultaneous requests: resolved strictly by rotation. A request that arrives during GAP is considered only in IDLE.
- `gap_cycles` changes outside the DRAIN→GAP edge have no effect on the current gap.
- `burst_cnt` is 16 bits and never wraps, because exit happens at MAX_BURST.

## Structure
- Shared package `uart_pkg` holds the state encoding (`UART_ARB_IDLE`..`UART_ARB_GAP`) and the `PORTS` limit constant.
- One sub-module, `uart_rr_pick`: a combinational round-robin picker with inputs `req[PORTS]` and `last` (index) and output `onehot[PORTS]`. It is reusable by other arbiters.
- Everything else stays in `uart_tx_arb`: FSM, output register, counters.

## Test plan
- Reset then single packet: port 2 sends 3 bytes 0x11, 0x22, 0x33 (last), sink always ready, `gap_cycles` = 4.
  - `m_axis` carries 0x11, 0x22, 0x33 back-to-back.
  - `grant` = 0b0100 until DRAIN ends.
  - `tx_busy` low → 4 GAP clocks → IDLE.
- All 4 ports request 1-byte packets continuously.
  - Grants rotate 0, 1, 2, 3, 0.
  - No port is served twice before the others.
- MAX_BURST = 4: port 1 sends a 10-byte packet while port 3 also requests.
  - Sequence: 4 bytes from port 1, then 4 from port 3 (or its full packet), then port 1 resumes.
- Backpressure: `m_axis_tready` toggles 1010…, and `tx_busy` is held high 20 clocks after the last byte.
  - No byte is lost or duplicated.
  - DRAIN holds until `tx_busy` falls.
- `gap_cycles` = 0: next grant is issued exactly 1 clock after `tx_busy` falls and `m_axis_tvalid` = 0.
- Assert `rst_n` low mid-packet.
  - All outputs return to reset values asynchronously.
  - After release, port 0 wins a simultaneous 0/1 request.
